// File: rtl/regbank_write_port.sv
// regbank_write_port
//
// Write side of the 32 x 32-bit general register bank. Owns the registers
// and presents them flattened on Regs for the 32-to-1 read selector.
// Write requests enter a 2-entry FIFO through a valid/ready handshake and
// are committed one per cycle with per-byte enables. A sequenced bulk clear
// (IDLE -> DRAIN -> CLEAR -> IDLE) zeroes all registers one per cycle, and
// Hold freezes commits, the clear counter and state transitions.
//
// Ports:
//   Clk       in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   WrValid   in   write request valid
//   WrReady   out  queue can accept a request this cycle (combinational)
//   WrAddr    in   [4:0]  destination register index
//   WrData    in   [31:0] write data
//   WrMask    in   [3:0]  byte enables, bit i selects WrData[8i+7:8i]
//   Hold      in   freeze commits and clear sequencing
//   ClearReq  in   bulk clear request, sampled in IDLE only
//   Busy      out  high while in DRAIN or CLEAR (combinational)
//   LoadEn    out  [31:0] registered one-hot of the register loaded at the last edge
//   Regs      out  [1023:0] register k on bits [32k+31:32k]
//
// Optional feature macro: REGBANK_R0_ZERO_EN
//   When defined, register 0 reads as constant zero; writes to address 0
//   are still dequeued but discarded and do not pulse LoadEn.

module regbank_write_port #(
  parameter int DEPTH = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          WrValid,
  output logic          WrReady,
  input  logic [4:0]    WrAddr,
  input  logic [31:0]   WrData,
  input  logic [3:0]    WrMask,
  input  logic          Hold,
  input  logic          ClearReq,
  output logic          Busy,
  output logic [31:0]   LoadEn,
  output logic [1023:0] Regs
);

`ifdef REGBANK_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  clr_cnt_q, clr_cnt_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [4:0]  q_addr_q [DEPTH];
  logic [31:0] q_data_q [DEPTH];
  logic [3:0]  q_mask_q [DEPTH];
  logic [31:0] regs_q   [32];
  logic [31:0] load_en_q, load_en_d;

  logic        push, pop, clr_step;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [3:0]  head_mask;
  logic [31:0] wr_onehot, clr_onehot;

  assign WrReady = (count_q < DEPTH_CNT) && (state_q == ST_IDLE);
  assign Busy    = (state_q != ST_IDLE);
  assign LoadEn  = load_en_q;

  assign head_addr = q_addr_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];
  assign head_mask = q_mask_q[rd_ptr_q];

  for (genvar k = 0; k < 32; k++) begin : g_flat
    assign Regs[32*k +: 32] = regs_q[k];
  end

  always_comb begin
    push     = WrValid && WrReady;
    pop      = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) && !Hold && (count_q != 2'd0);
    clr_step = (state_q == ST_CLEAR) && !Hold;

    // One-hot decode of the committing address and of the clear index.
    // With register 0 hardwired, neither decode ever selects it, so it
    // keeps its reset value of zero and never pulses LoadEn.
    wr_onehot  = pop      ? (32'd1 << head_addr) : 32'd0;
    clr_onehot = clr_step ? (32'd1 << clr_cnt_q) : 32'd0;
    if (R0_ZERO) begin
      wr_onehot[0]  = 1'b0;
      clr_onehot[0] = 1'b0;
    end
    load_en_d = wr_onehot | clr_onehot;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE:  if (!Hold && ClearReq) state_d = ST_DRAIN;
      // Leave DRAIN only once the queue was already empty at this edge.
      ST_DRAIN: if (!Hold && (count_q == 2'd0)) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (!Hold) begin
          clr_cnt_d = clr_cnt_q + 5'd1;
          if (clr_cnt_q == 5'd31) state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      load_en_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
        q_mask_q[i] <= '0;
      end
      for (int k = 0; k < 32; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      count_q   <= count_d;
      load_en_q <= load_en_d;
      if (push) begin
        q_addr_q[wr_ptr_q] <= WrAddr;
        q_data_q[wr_ptr_q] <= WrData;
        q_mask_q[wr_ptr_q] <= WrMask;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      // Commit and clear never coincide: commits happen only in IDLE/DRAIN.
      for (int k = 0; k < 32; k++) begin
        if (clr_onehot[k]) begin
          regs_q[k] <= '0;
        end else if (wr_onehot[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (head_mask[b]) regs_q[k][8*b +: 8] <= head_data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_port.sv
module tb_regbank_write_port;

`ifdef REGBANK_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic          Clk      = 1'b0;
  logic          Reset_n  = 1'b1;
  logic          WrValid  = 1'b0;
  logic          Hold     = 1'b0;
  logic          ClearReq = 1'b0;
  logic [4:0]    WrAddr   = '0;
  logic [31:0]   WrData   = '0;
  logic [3:0]    WrMask   = '0;
  logic          WrReady;
  logic          Busy;
  logic [31:0]   LoadEn;
  logic [1023:0] Regs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  regbank_write_port #(.DEPTH(2)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .WrValid  (WrValid),
    .WrReady  (WrReady),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .WrMask   (WrMask),
    .Hold     (Hold),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .LoadEn   (LoadEn),
    .Regs     (Regs)
  );

  function automatic logic [31:0] reg_of(int k);
    return Regs[32*k +: 32];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one request for exactly one edge.
  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    WrValid = 1'b1; WrAddr = a; WrData = d; WrMask = m;
    tick();
    WrValid = 1'b0;
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    #1;
    total_cnt++;
    if (Regs !== '0) $display("FAIL reset_regs: got %h want 0", Regs); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL reset_loaden: got %h want 0", LoadEn); else pass_cnt++;
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else pass_cnt++;
    #2 Reset_n = 1'b1;
    #1;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL reset_wrready: got %b want 1", WrReady); else pass_cnt++;
    tick();
  endtask

  task automatic test_write_full();
    WrValid = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF; WrMask = 4'hF;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL full_ready: got %b want 1", WrReady); else pass_cnt++;
    tick();
    WrValid = 1'b0;
    total_cnt++;
    if (reg_of(5) !== 32'h0) $display("FAIL full_latency: got %h want 00000000", reg_of(5)); else pass_cnt++;
    tick();
    total_cnt++;
    if (reg_of(5) !== 32'hDEADBEEF) $display("FAIL full_data: got %h want deadbeef", reg_of(5)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h00000020) $display("FAIL full_loaden: got %h want 00000020", LoadEn); else pass_cnt++;
    tick();
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL full_loaden_idle: got %h want 0", LoadEn); else pass_cnt++;
  endtask

  task automatic test_partial();
    push(5'd5, 32'h11223344, 4'h5);
    tick();
    total_cnt++;
    if (reg_of(5) !== 32'hDE22BE44) $display("FAIL partial_data: got %h want de22be44", reg_of(5)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h00000020) $display("FAIL partial_loaden: got %h want 00000020", LoadEn); else pass_cnt++;
    push(5'd5, 32'hFFFFFFFF, 4'h0);
    tick();
    total_cnt++;
    if (reg_of(5) !== 32'hDE22BE44) $display("FAIL mask0_data: got %h want de22be44", reg_of(5)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h00000020) $display("FAIL mask0_loaden: got %h want 00000020", LoadEn); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    WrValid = 1'b1; WrAddr = 5'd10; WrData = 32'hA0A0A0A0; WrMask = 4'hF;
    tick();
    WrAddr = 5'd11; WrData = 32'hB1B1B1B1;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL b2b_ready: got %b want 1", WrReady); else pass_cnt++;
    tick();
    total_cnt++;
    if (reg_of(10) !== 32'hA0A0A0A0) $display("FAIL b2b_r10: got %h want a0a0a0a0", reg_of(10)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h00000400) $display("FAIL b2b_le10: got %h want 00000400", LoadEn); else pass_cnt++;
    WrAddr = 5'd12; WrData = 32'hC2C2C2C2;
    tick();
    WrValid = 1'b0;
    total_cnt++;
    if (reg_of(11) !== 32'hB1B1B1B1) $display("FAIL b2b_r11: got %h want b1b1b1b1", reg_of(11)); else pass_cnt++;
    tick();
    total_cnt++;
    if (reg_of(12) !== 32'hC2C2C2C2) $display("FAIL b2b_r12: got %h want c2c2c2c2", reg_of(12)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h00001000) $display("FAIL b2b_le12: got %h want 00001000", LoadEn); else pass_cnt++;
  endtask

  task automatic test_hold();
    Hold = 1'b1;
    WrValid = 1'b1; WrAddr = 5'd7; WrData = 32'h000000AA; WrMask = 4'hF;
    tick();
    WrData = 32'h0000BB00;
    tick();
    WrData = 32'hCCCCCCCC;
    total_cnt++;
    if (WrReady !== 1'b0) $display("FAIL hold_full_ready: got %b want 0", WrReady); else pass_cnt++;
    tick();
    WrValid = 1'b0;
    total_cnt++;
    if (reg_of(7) !== 32'h0) $display("FAIL hold_frozen: got %h want 0", reg_of(7)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL hold_loaden: got %h want 0", LoadEn); else pass_cnt++;
    Hold = 1'b0;
    tick();
    total_cnt++;
    if (reg_of(7) !== 32'h000000AA) $display("FAIL hold_first: got %h want 000000aa", reg_of(7)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h00000080) $display("FAIL hold_first_le: got %h want 00000080", LoadEn); else pass_cnt++;
    tick();
    total_cnt++;
    if (reg_of(7) !== 32'h0000BB00) $display("FAIL hold_second: got %h want 0000bb00", reg_of(7)); else pass_cnt++;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL hold_ready_back: got %b want 1", WrReady); else pass_cnt++;
    tick();
    total_cnt++;
    if (reg_of(7) !== 32'h0000BB00) $display("FAIL hold_third_dropped: got %h want 0000bb00", reg_of(7)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL hold_le_after: got %h want 0", LoadEn); else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [31:0] exp_le;
    WrValid = 1'b1; WrAddr = 5'd31; WrData = 32'h31313131; WrMask = 4'hF;
    ClearReq = 1'b1;
    tick();
    WrValid = 1'b0; ClearReq = 1'b0;
    total_cnt++;
    if (Busy !== 1'b1) $display("FAIL clr_busy_drain: got %b want 1", Busy); else pass_cnt++;
    total_cnt++;
    if (WrReady !== 1'b0) $display("FAIL clr_ready_drain: got %b want 0", WrReady); else pass_cnt++;
    tick();
    total_cnt++;
    if (reg_of(31) !== 32'h31313131) $display("FAIL clr_drain_commit: got %h want 31313131", reg_of(31)); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h80000000) $display("FAIL clr_drain_le: got %h want 80000000", LoadEn); else pass_cnt++;
    tick();
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL clr_enter_le: got %h want 0", LoadEn); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_le = (R0_ZERO && i == 0) ? 32'h0 : (32'd1 << i);
      total_cnt++;
      if (LoadEn !== exp_le) $display("FAIL clr_le_%0d: got %h want %h", i, LoadEn, exp_le); else pass_cnt++;
      if (i < 31) begin
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL clr_busy_%0d: got %b want 1", i, Busy); else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++;
        if (reg_of(5) !== 32'hDE22BE44) $display("FAIL clr_r5_kept: got %h want de22be44", reg_of(5)); else pass_cnt++;
      end
      if (i == 5) begin
        total_cnt++;
        if (reg_of(5) !== 32'h0) $display("FAIL clr_r5_zeroed: got %h want 0", reg_of(5)); else pass_cnt++;
      end
    end
    total_cnt++;
    if (Regs !== '0) $display("FAIL clr_all_zero: got %h want 0", Regs); else pass_cnt++;
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL clr_busy_end: got %b want 0", Busy); else pass_cnt++;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL clr_ready_end: got %b want 1", WrReady); else pass_cnt++;
    tick();
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL clr_le_end: got %h want 0", LoadEn); else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    push(5'd20, 32'h20202020, 4'hF);
    tick();
    push(5'd25, 32'h25252525, 4'hF);
    tick();
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) tick();
    total_cnt++;
    if (LoadEn !== 32'h00010000) $display("FAIL mid_le16: got %h want 00010000", LoadEn); else pass_cnt++;
    total_cnt++;
    if (reg_of(20) !== 32'h20202020) $display("FAIL mid_r20: got %h want 20202020", reg_of(20)); else pass_cnt++;
    #2 Reset_n = 1'b0;
    #1;
    total_cnt++;
    if (Regs !== '0) $display("FAIL mid_rst_regs: got %h want 0", Regs); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== 32'h0) $display("FAIL mid_rst_le: got %h want 0", LoadEn); else pass_cnt++;
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", Busy); else pass_cnt++;
    #2 Reset_n = 1'b1;
    #1;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", WrReady); else pass_cnt++;
    // A fresh clear must restart from index 0.
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    tick();
    tick();
    tick();
    total_cnt++;
    if (LoadEn !== 32'h00000002) $display("FAIL mid_cnt_restart: got %h want 00000002", LoadEn); else pass_cnt++;
    for (int i = 0; i < 30; i++) tick();
    total_cnt++;
    if (Busy !== 1'b0) $display("FAIL mid_second_clear_end: got %b want 0", Busy); else pass_cnt++;
  endtask

  task automatic test_r0();
    logic [31:0] exp_r0;
    logic [31:0] exp_le;
    exp_r0 = R0_ZERO ? 32'h0 : 32'hFFFFFFFF;
    exp_le = R0_ZERO ? 32'h0 : 32'h00000001;
    push(5'd0, 32'hFFFFFFFF, 4'hF);
    tick();
    total_cnt++;
    if (reg_of(0) !== exp_r0) $display("FAIL r0_data: got %h want %h", reg_of(0), exp_r0); else pass_cnt++;
    total_cnt++;
    if (LoadEn !== exp_le) $display("FAIL r0_loaden: got %h want %h", LoadEn, exp_le); else pass_cnt++;
    total_cnt++;
    if (WrReady !== 1'b1) $display("FAIL r0_popped: got %b want 1", WrReady); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_full();
    test_partial();
    test_back_to_back();
    test_hold();
    test_clear();
    test_reset_mid_clear();
    test_r0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
